// File: rtl/rf_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_scheduler
// Description : Two-requester register-file write arbiter with registered write
//               port, pending-write scoreboard, hazard check and conflict count.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_scheduler #(
    parameter int DATA_W = 32,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr0_valid,
    input  logic [4:0]        wr0_reg,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_ready,
    input  logic              wr1_valid,
    input  logic [4:0]        wr1_reg,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_ready,
    output logic              rf_rw,
    output logic [4:0]        rf_rsd,
    output logic [DATA_W-1:0] rf_data,
    input  logic              mark_valid,
    input  logic [4:0]        mark_reg,
    input  logic [4:0]        chk_rs1,
    input  logic [4:0]        chk_rs2,
    output logic              hazard,
    output logic [31:0]       busy,
    output logic [15:0]       conflict_cnt
);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    // r_last_grant = 1 means requester 1 was granted most recently
    logic              r_last_grant;
    logic              r_rf_rw;
    logic [4:0]        r_rf_rsd;
    logic [DATA_W-1:0] r_rf_data;
    logic [31:0]       r_busy;
    logic [15:0]       r_conflict_cnt;

    logic              w_g0;
    logic              w_g1;
    logic              w_xfer;
    logic [4:0]        w_sel_reg;
    logic [DATA_W-1:0] w_sel_data;
    logic [31:0]       w_set;
    logic [31:0]       w_clr;
    logic [31:0]       w_busy_nxt;

    always_comb begin
        w_g0 = 1'b0;
        w_g1 = 1'b0;
        if (rst_n) begin
            if (wr0_valid && (!wr1_valid || (RR_EN == 0) || r_last_grant))
                w_g0 = 1'b1;
            else if (wr1_valid)
                w_g1 = 1'b1;
        end
    end

    assign wr0_ready  = w_g0;
    assign wr1_ready  = w_g1;
    assign w_xfer     = w_g0 | w_g1;
    assign w_sel_reg  = w_g0 ? wr0_reg  : wr1_reg;
    assign w_sel_data = w_g0 ? wr0_data : wr1_data;

    // Scoreboard: a mark on the same edge as the commit of that register wins
    assign w_set      = (mark_valid && (mark_reg != 5'd0)) ? (32'd1 << mark_reg) : 32'd0;
    assign w_clr      = r_rf_rw ? (32'd1 << r_rf_rsd) : 32'd0;
    assign w_busy_nxt = (r_busy & ~w_clr) | w_set;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant   <= 1'b1;
            r_rf_rw        <= 1'b0;
            r_rf_rsd       <= 5'd0;
            r_rf_data      <= '0;
            r_busy         <= 32'd0;
            r_conflict_cnt <= 16'd0;
        end else begin
            if (w_xfer)
                r_last_grant <= w_g1;
            r_rf_rw <= w_xfer && (w_sel_reg != 5'd0);
            if (w_xfer && (w_sel_reg != 5'd0)) begin
                r_rf_rsd  <= w_sel_reg;
                r_rf_data <= w_sel_data;
            end
            r_busy <= {w_busy_nxt[31:1], 1'b0};
            if (wr0_valid && wr1_valid && (r_conflict_cnt != c_CNT_MAX))
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign rf_rw        = r_rf_rw;
    assign rf_rsd       = r_rf_rsd;
    assign rf_data      = r_rf_data;
    assign busy         = r_busy;
    assign conflict_cnt = r_conflict_cnt;
    assign hazard       = r_busy[chk_rs1] | r_busy[chk_rs2];

endmodule
`default_nettype wire

// File: doc/rf_write_scheduler.md
RF_WRITE_SCHEDULER -- requirements
Module: rf_write_scheduler

Interface
REQ-001 Parameter: DATA_W, 32, write-data width to the register file.
REQ-002 Parameter: RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority to requester 0.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 wr0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-006 wr0_reg  input  5  requester 0 destination register.
REQ-007 wr0_data  input  DATA_W  requester 0 write data.
REQ-008 wr0_ready  output  1  requester 0 write accepted this cycle.
REQ-009 wr1_valid / wr1_reg / wr1_data / wr1_ready: same widths, directions and meanings as requester 0, for requester 1 (load unit).
REQ-010 rf_rw  output  1  register-file write enable.
REQ-011 rf_rsd  output  5  register-file write address.
REQ-012 rf_data  output  DATA_W  register-file write data.
REQ-013 mark_valid  input  1  issue stage claims a destination register.
REQ-014 mark_reg  input  5  register being claimed.
REQ-015 chk_rs1, chk_rs2  input  5 each  source registers of the instruction in issue.
REQ-016 hazard  output  1  a checked source has a write outstanding.
REQ-017 busy  output  32  scoreboard bitmap, bit n = register n pending.
REQ-018 conflict_cnt  output  16  count of cycles in which both requesters were valid.

Function
REQ-019 Handshake: a write transfers in a cycle where wrN_valid and wrN_ready are both 1; at most one of wr0_ready/wr1_ready is 1 per cycle.
REQ-020 wrN_ready is combinational from the valids and the last-grant flop; it does not depend on rf_* outputs.
REQ-021 One valid only: that requester is granted.
REQ-022 Both valid, RR_EN=1: the requester not granted most recently wins; last-grant updates on every transfer.
REQ-023 Both valid, RR_EN=0: requester 0 always wins; requester 1 waits.
REQ-024 rf_rw, rf_rsd, rf_data are registered: one cycle after a transfer they carry the accepted reg/data with rf_rw=1; otherwise rf_rw=0 and rf_rsd/rf_data hold.
REQ-025 A transfer with destination 0 is accepted (ready=1) but produces rf_rw=0 on the next cycle.
REQ-026 busy[n] sets on the edge where mark_valid=1 and mark_reg=n, n≠0.
REQ-027 busy[n] clears on the edge where rf_rw=1 and rf_rsd=n (the edge the register file commits the write).
REQ-028 Simultaneous set and clear of the same bit: set wins.
REQ-029 busy[0] is constant 0.
REQ-030 hazard = busy[chk_rs1] | busy[chk_rs2], combinational.
REQ-031 conflict_cnt increments on each edge where wr0_valid and wr1_valid are both 1; saturates at 0xFFFF.
REQ-032 A requester may hold valid with changing reg/data until accepted; only the values in the transfer cycle are used.

Reset
REQ-033 While rst_n=0 at a posedge: busy=0, rf_rw=0, rf_rsd=0, rf_data=0, conflict_cnt=0, last-grant = requester 1, so requester 0 wins the first conflict.
REQ-034 While rst_n=0, wr0_ready=wr1_ready=0 and mark_valid is ignored.
REQ-035 A write accepted in the cycle before reset is asserted is discarded: rf_rw=0 after the reset edge.

Verification
REQ-036 Reset, then wr0 valid alone, reg 5, data 0x1234 -> wr0_ready=1; next cycle rf_rw=1, rf_rsd=5, rf_data=0x1234.
REQ-037 RR_EN=1, both valid for 4 cycles (reg 3 / reg 4) -> grants 0,1,0,1; conflict_cnt=4.
REQ-038 RR_EN=0, both valid for 3 cycles -> wr0_ready=1 every cycle, wr1_ready=0.
REQ-039 mark reg 7, chk_rs1=7 -> hazard=1; wr1 writes reg 7 -> hazard=0 after the edge where rf_rw=1, rf_rsd=7.
REQ-040 mark reg 9 on the same edge that commits reg 9 -> busy[9]=1 remains set; wr0 to reg 0 -> accepted, rf_rw=0, busy unchanged.
REQ-041 Assert rst_n=0 with busy=0x0000_0880 and conflict_cnt=0x0010 -> after the edge busy=0, conflict_cnt=0, rf_rw=0, readies=0.
